// File: rtl/araddr_fifo_sched.sv
// Two-requester read-command splitter that feeds AXI-style burst descriptors to an address FIFO.
// Optional per-requester burst counters are enabled with ARADDR_SCHED_STAT_EN.
module araddr_fifo_sched #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BEATS_WIDTH = 16,
    parameter int MAX_BURST   = 16,
    parameter int BEAT_BYTES  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd0_valid,
    input  logic                    cmd1_valid,
    output logic                    cmd0_ready,
    output logic                    cmd1_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd0_addr,
    input  logic [ADDR_WIDTH-1:0]   cmd1_addr,
    input  logic [BEATS_WIDTH-1:0]  cmd0_beats,
    input  logic [BEATS_WIDTH-1:0]  cmd1_beats,
    output logic                    fifo_wr_en,
    output logic [ADDR_WIDTH+8:0]   fifo_wr_data,
    input  logic                    fifo_wr_full,
    output logic                    busy,
    output logic                    grant_id
`ifdef ARADDR_SCHED_STAT_EN
    ,
    output logic [15:0]             stat_bursts0,
    output logic [15:0]             stat_bursts1
`endif
);

    typedef enum logic {IDLE, ISSUE} state_e;

    localparam int BW = (BEATS_WIDTH > 9) ? BEATS_WIDTH : 9;
    localparam int SH = $clog2(BEAT_BYTES);

    state_e                  state_q, state_d;
    logic                    gid_q, gid_d;
    logic                    pri_q, pri_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BEATS_WIDTH-1:0]  rem_q, rem_d;

    logic                    grant;
    logic [BW-1:0]           rem_x;
    logic [BW-1:0]           burst;
    logic [BW+SH-1:0]        step;

    always_comb begin
        rem_x        = BW'(rem_q);
        burst        = (rem_x < BW'(MAX_BURST)) ? rem_x : BW'(MAX_BURST);
        step         = (BW+SH)'(burst) << SH;
        state_d      = state_q;
        gid_d        = gid_q;
        pri_d        = pri_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        grant        = 1'b0;
        cmd0_ready   = 1'b0;
        cmd1_ready   = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        unique case (state_q)
            IDLE: begin
                if (cmd0_valid || cmd1_valid) begin
                    // pri_q names the requester that wins a tie
                    grant      = (cmd0_valid && cmd1_valid) ? pri_q : cmd1_valid;
                    cmd0_ready = !grant;
                    cmd1_ready = grant;
                    gid_d      = grant;
                    pri_d      = !grant;
                    addr_d     = grant ? cmd1_addr : cmd0_addr;
                    rem_d      = grant ? cmd1_beats : cmd0_beats;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (rem_q == '0) begin
                    state_d = IDLE;
                end else if (!fifo_wr_full) begin
                    fifo_wr_en   = 1'b1;
                    fifo_wr_data = {gid_q, addr_q, 8'(burst - BW'(1))};
                    addr_d       = addr_q + ADDR_WIDTH'(step);
                    rem_d        = rem_q - BEATS_WIDTH'(burst);
                    if (rem_x == burst) state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gid_q   <= 1'b0;
            pri_q   <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            pri_q   <= pri_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    assign busy     = (state_q == ISSUE);
    assign grant_id = gid_q;

`ifdef ARADDR_SCHED_STAT_EN
    logic [15:0] st0_q, st0_d;
    logic [15:0] st1_q, st1_d;

    always_comb begin
        st0_d = st0_q;
        st1_d = st1_q;
        if (fifo_wr_en && !gid_q && st0_q != 16'hFFFF) st0_d = st0_q + 16'd1;
        if (fifo_wr_en && gid_q && st1_q != 16'hFFFF) st1_d = st1_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0_q <= '0;
            st1_q <= '0;
        end else begin
            st0_q <= st0_d;
            st1_q <= st1_d;
        end
    end

    assign stat_bursts0 = st0_q;
    assign stat_bursts1 = st1_q;
`endif

endmodule

// File: tb/tb_araddr_fifo_sched.sv
// Randomised and directed bench for araddr_fifo_sched against a queue-based burst model.
// Stat counters are checked when ARADDR_SCHED_STAT_EN is defined.
module tb_araddr_fifo_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd0_valid, cmd1_valid;
    logic        cmd0_ready, cmd1_ready;
    logic [27:0] cmd0_addr, cmd1_addr;
    logic [15:0] cmd0_beats, cmd1_beats;
    logic        fifo_wr_en;
    logic [36:0] fifo_wr_data;
    logic        fifo_wr_full;
    logic        busy, grant_id;
`ifdef ARADDR_SCHED_STAT_EN
    logic [15:0] stat_bursts0, stat_bursts1;
`endif

    always #5 clk = ~clk;

    araddr_fifo_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd0_valid   (cmd0_valid),
        .cmd1_valid   (cmd1_valid),
        .cmd0_ready   (cmd0_ready),
        .cmd1_ready   (cmd1_ready),
        .cmd0_addr    (cmd0_addr),
        .cmd1_addr    (cmd1_addr),
        .cmd0_beats   (cmd0_beats),
        .cmd1_beats   (cmd1_beats),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_full (fifo_wr_full),
        .busy         (busy),
        .grant_id     (grant_id)
`ifdef ARADDR_SCHED_STAT_EN
        ,
        .stat_bursts0 (stat_bursts0),
        .stat_bursts1 (stat_bursts1)
`endif
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // model: a granted command becomes a list of {addr,len} bursts
    bit          m_busy, m_gid, m_pri;
    logic [35:0] mq[$];
    int          m_st0, m_st1;
    bit          acc0, acc1;

    logic [36:0] wlog[$];
    int          busy_cyc, rdy0_cnt;

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        total_cnt++;
        if (a !== e)
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        else
            pass_cnt++;
    endfunction

    function automatic void model_reset();
        m_busy = 0;
        m_gid  = 0;
        m_pri  = 0;
        mq.delete();
        m_st0  = 0;
        m_st1  = 0;
    endfunction

    function automatic void build(logic [27:0] a, int beats);
        int r, b;
        r = beats;
        mq.delete();
        while (r > 0) begin
            b = (r < 16) ? r : 16;
            mq.push_back({a, 8'(b - 1)});
            a = a + 28'(b * 32);
            r = r - b;
        end
    endfunction

    task automatic step();
        bit          er0, er1, ew, g;
        logic [36:0] ed;
        #1;
        er0 = 0; er1 = 0; ew = 0; g = 0; ed = '0;
        if (!m_busy) begin
            if (cmd0_valid || cmd1_valid) begin
                g   = (cmd0_valid && cmd1_valid) ? m_pri : cmd1_valid;
                er0 = !g;
                er1 = g;
            end
        end else if (mq.size() > 0 && !fifo_wr_full) begin
            ew = 1;
            ed = {m_gid, mq[0]};
        end
        chk("cmd0_ready", 64'(cmd0_ready), 64'(er0));
        chk("cmd1_ready", 64'(cmd1_ready), 64'(er1));
        chk("fifo_wr_en", 64'(fifo_wr_en), 64'(ew));
        chk("fifo_wr_data", 64'(fifo_wr_data), 64'(ed));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
`ifdef ARADDR_SCHED_STAT_EN
        chk("stat0", 64'(stat_bursts0), 64'(m_st0));
        chk("stat1", 64'(stat_bursts1), 64'(m_st1));
`endif
        if (fifo_wr_en) wlog.push_back(fifo_wr_data);
        if (busy) busy_cyc++;
        if (cmd0_ready) rdy0_cnt++;
        @(posedge clk);
        if (!m_busy) begin
            if (er0 || er1) begin
                m_busy = 1;
                m_gid  = g;
                m_pri  = !g;
                build(g ? cmd1_addr : cmd0_addr, int'(g ? cmd1_beats : cmd0_beats));
            end
        end else if (mq.size() == 0) begin
            m_busy = 0;
        end else if (ew) begin
            void'(mq.pop_front());
            if (m_gid) m_st1 = (m_st1 < 65535) ? m_st1 + 1 : m_st1;
            else       m_st0 = (m_st0 < 65535) ? m_st0 + 1 : m_st0;
            if (mq.size() == 0) m_busy = 0;
        end
        acc0 = er0;
        acc1 = er1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready0", 64'(cmd0_ready), 0);
        chk("rst_ready1", 64'(cmd1_ready), 0);
        chk("rst_wr_en", 64'(fifo_wr_en), 0);
        chk("rst_wr_data", 64'(fifo_wr_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_grant_id", 64'(grant_id), 0);
`ifdef ARADDR_SCHED_STAT_EN
        chk("rst_stat0", 64'(stat_bursts0), 0);
        chk("rst_stat1", 64'(stat_bursts1), 0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_cmds(input bit e0, input bit e1,
                            input logic [27:0] a0, input logic [27:0] a1,
                            input int b0, input int b1,
                            input int st, input int sl);
        bit done;
        wlog.delete();
        busy_cyc   = 0;
        rdy0_cnt   = 0;
        cmd0_valid = e0;
        cmd1_valid = e1;
        cmd0_addr  = a0;
        cmd1_addr  = a1;
        cmd0_beats = 16'(b0);
        cmd1_beats = 16'(b1);
        done       = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            fifo_wr_full = (k >= st && k < st + sl);
            step();
            if (acc0) cmd0_valid = 0;
            if (acc1) cmd1_valid = 0;
            if (!m_busy && !cmd0_valid && !cmd1_valid) done = 1;
        end
        fifo_wr_full = 0;
        cmd0_valid   = 0;
        cmd1_valid   = 0;
        chk("cmd_done", 64'(done), 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd0_valid   = 0;
        cmd1_valid   = 0;
        cmd0_addr    = '0;
        cmd1_addr    = '0;
        cmd0_beats   = '0;
        cmd1_beats   = '0;
        fifo_wr_full = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // 40 beats from 0: three bursts
        run_cmds(1, 0, 28'h0, 28'h0, 40, 0, -1, 0);
        chk("r31_n", 64'(wlog.size()), 3);
        chk("r31_w0", 64'(wlog[0]), 64'({1'b0, 28'h000_0000, 8'd15}));
        chk("r31_w1", 64'(wlog[1]), 64'({1'b0, 28'h000_0200, 8'd15}));
        chk("r31_w2", 64'(wlog[2]), 64'({1'b0, 28'h000_0400, 8'd7}));
        chk("r31_busy", 64'(busy_cyc), 3);

        // both requesting right after reset
        @(negedge clk);
        do_reset();
        run_cmds(1, 1, 28'h000_1000, 28'h000_2000, 16, 16, -1, 0);
        chk("r32_n", 64'(wlog.size()), 2);
        chk("r32_w0", 64'(wlog[0]), 64'({1'b0, 28'h000_1000, 8'd15}));
        chk("r32_w1", 64'(wlog[1]), 64'({1'b1, 28'h000_2000, 8'd15}));

        // five-cycle stall after the first burst
        run_cmds(1, 0, 28'h000_3000, 28'h0, 48, 0, 2, 5);
        chk("r33_n", 64'(wlog.size()), 3);
        chk("r33_w0", 64'(wlog[0]), 64'({1'b0, 28'h000_3000, 8'd15}));
        chk("r33_w1", 64'(wlog[1]), 64'({1'b0, 28'h000_3200, 8'd15}));
        chk("r33_w2", 64'(wlog[2]), 64'({1'b0, 28'h000_3400, 8'd15}));
        chk("r33_busy", 64'(busy_cyc), 8);

        // address wraps past the top
        run_cmds(0, 1, 28'h0, 28'hFFF_FE00, 0, 32, -1, 0);
        chk("r34_n", 64'(wlog.size()), 2);
        chk("r34_w0", 64'(wlog[0]), 64'({1'b1, 28'hFFF_FE00, 8'd15}));
        chk("r34_w1", 64'(wlog[1]), 64'({1'b1, 28'h000_0000, 8'd15}));

        // zero-beat command
        run_cmds(1, 0, 28'h000_5000, 28'h0, 0, 0, -1, 0);
        chk("r35_n", 64'(wlog.size()), 0);
        chk("r35_ready", 64'(rdy0_cnt), 1);
        chk("r35_busy", 64'(busy_cyc), 1);

        // reset while the second burst is on the port
        wlog.delete();
        cmd0_valid = 1;
        cmd0_addr  = 28'h0;
        cmd0_beats = 16'd64;
        step();
        cmd0_valid = 0;
        step();
        chk("r36_pre_wr", 64'(fifo_wr_en), 1);
        do_reset();
        repeat (4) step();
        chk("r36_n", 64'(wlog.size()), 1);

        // random traffic with random back-pressure
        for (int k = 0; k < 600; k++) begin
            if (!cmd0_valid && $urandom_range(0, 2) == 0) begin
                cmd0_valid = 1;
                cmd0_addr  = $urandom_range(0, 1) ? 28'($urandom)
                                                  : 28'hFFF_FFFF - 28'($urandom_range(0, 2048));
                cmd0_beats = 16'($urandom_range(0, 70));
            end
            if (!cmd1_valid && $urandom_range(0, 2) == 0) begin
                cmd1_valid = 1;
                cmd1_addr  = $urandom_range(0, 1) ? 28'($urandom)
                                                  : 28'hFFF_FFFF - 28'($urandom_range(0, 2048));
                cmd1_beats = 16'($urandom_range(0, 70));
            end
            fifo_wr_full = ($urandom_range(0, 3) == 0);
            step();
            if (acc0) cmd0_valid = 0;
            if (acc1) cmd1_valid = 0;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
